// File: rtl/shift_mul_add.sv
// Sequential shift-add multiplier with addend: product = multiplicand * multiplier + addend.
// Processes one multiplier bit per ADD/SHIFT pair, using the same start/done handshake as the shift divider.
module shift_mul_add #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     addend,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADD,
        SHIFT,
        ACC,
        END
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] c_r;
    logic [WIDTH:0]   hi;
    logic [WIDTH-1:0] lo;
    logic [CNT_W-1:0] cnt;
    logic             zero_r;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (multiplicand == '0 || multiplier == '0) ? ACC : ADD;
                end
            end
            ADD:     state_next = SHIFT;
            SHIFT:   state_next = (cnt == LAST_BIT) ? ACC : ADD;
            ACC:     state_next = END;
            END:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_r     <= '0;
            c_r     <= '0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            zero_r  <= 1'b0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            done <= (state == END);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r    <= multiplicand;
                        c_r    <= addend;
                        lo     <= multiplier;
                        hi     <= '0;
                        cnt    <= '0;
                        zero_r <= (multiplicand == '0 || multiplier == '0);
                    end
                end
                ADD: begin
                    if (lo[0]) begin
                        hi <= hi + {1'b0, a_r};
                    end
                end
                SHIFT: begin
                    // Right shift of the {hi,lo} pair; zero enters the carry bit.
                    hi  <= {1'b0, hi[WIDTH:1]};
                    lo  <= {hi[0], lo[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                end
                ACC: begin
                    if (zero_r) begin
                        product <= {{WIDTH{1'b0}}, c_r};
                    end else begin
                        product <= {hi[WIDTH-1:0], lo} + {{WIDTH{1'b0}}, c_r};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_shift_mul_add.sv
// Scoreboard bench for shift_mul_add (WIDTH=4): stimulus pushes expected product and done cycle,
// a monitor pops and compares on every done pulse.
module tb_shift_mul_add;

    localparam int W = 4;

    typedef struct {
        logic [2*W-1:0] prod;
        int             cyc;
        string          name;
    } exp_t;

    logic             clk;
    logic             rstn;
    logic             start;
    logic [W-1:0]     multiplicand;
    logic [W-1:0]     multiplier;
    logic [W-1:0]     addend;
    logic [2*W-1:0]   product;
    logic             busy;
    logic             done;

    exp_t sb[$];
    int   cyc;
    int   n_compared;
    int   n_mismatched;

    shift_mul_add #(.WIDTH(W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .addend       (addend),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        n_compared++;
        if (act !== exp_v) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rstn === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_product"}, int'(product), int'(e.prod));
                check({e.name, "_done_cycle"}, cyc, e.cyc);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drives start for exactly one cycle; the current cycle is cycle 0.
    task automatic applyStimulus(input string name, input int a, input int b, input int c,
                                 input int exp_prod, input int lat);
        exp_t e;
        multiplicand = W'(a);
        multiplier   = W'(b);
        addend       = W'(c);
        start        = 1'b1;
        e.prod = (2*W)'(exp_prod);
        e.cyc  = cyc + lat;
        e.name = name;
        sb.push_back(e);
        next_cycle();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            next_cycle();
            n++;
        end
        if (done !== 1'b1) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL %s_timeout: got no done expected done within 40 cycles", name);
        end
    endtask

    initial begin
        cyc          = 0;
        n_compared   = 0;
        n_mismatched = 0;
        rstn         = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        addend       = '0;
        repeat (3) next_cycle();
        check("reset_product", int'(product), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rstn = 1'b1;
        repeat (2) next_cycle();

        // 13*11+7 = 150 with busy profile over cycles 1..11
        applyStimulus("t1", 13, 11, 7, 150, 11);
        for (int k = 1; k <= 11; k++) begin
            check($sformatf("t1_busy_c%0d", k), int'(busy), (k <= 10) ? 1 : 0);
            if (k < 11) next_cycle();
        end
        check("t1_done_c11", int'(done), 1);
        next_cycle();
        check("t1_done_falls", int'(done), 0);
        repeat (2) next_cycle();
        check("t1_product_held", int'(product), 150);

        // Maximum result 15*15+15 = 240
        applyStimulus("t2", 15, 15, 15, 240, 11);
        wait_done("t2");
        next_cycle();

        // Zero shortcuts
        applyStimulus("t3a", 0, 9, 5, 5, 3);
        wait_done("t3a");
        next_cycle();
        applyStimulus("t3b", 9, 0, 0, 0, 3);
        wait_done("t3b");
        next_cycle();

        // Back-to-back: second start in the first done cycle
        applyStimulus("t4a", 3, 5, 2, 17, 11);
        wait_done("t4a");
        applyStimulus("t4b", 6, 7, 1, 43, 11);
        repeat (5) next_cycle();
        check("t4_held_mid", int'(product), 17);
        repeat (3) next_cycle();
        check("t4_held_acc", int'(product), 17);
        wait_done("t4b");
        next_cycle();

        // Start and operand churn while busy is ignored: 2*3+1 = 7
        applyStimulus("t5", 2, 3, 1, 7, 11);
        for (int k = 2; k <= 8; k++) begin
            multiplicand = W'(k + 5);
            multiplier   = W'(15 - k);
            addend       = W'(k);
            start        = k[0];
            next_cycle();
        end
        start = 1'b0;
        wait_done("t5");
        next_cycle();

        // Reset in cycle 5 aborts without a done pulse
        applyStimulus("t6", 13, 11, 7, 150, 11);
        repeat (4) next_cycle();
        rstn = 1'b0;
        #1;
        sb.delete();
        check("t6_rst_product", int'(product), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_done", int'(done), 0);
        next_cycle();
        rstn = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 15; k++) begin
                next_cycle();
                if (done === 1'b1) seen = 1;
            end
            check("t6_no_done_after_rst", seen, 0);
        end
        applyStimulus("t7", 12, 10, 9, 129, 11);
        wait_done("t7");
        next_cycle();

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/shift_mul_add.md
Name: shift_mul_add

Overview:
- Sequential shift-add multiplier with addend; the inverse of the n-bit shift divider.
- Computes product = multiplicand * multiplier + addend, so it rebuilds a dividend from quotient, divisor and remainder.
- Sits beside the divider in the arithmetic library and uses the same start/done handshake.
- One multiplier bit is processed per ADD/SHIFT pair.

Parameters:
- WIDTH, 4, operand bit width; legal range WIDTH >= 2. The product is 2*WIDTH bits.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- multiplicand  input  WIDTH  operand A (divisor when inverting a division).
- multiplier  input  WIDTH  operand B (quotient when inverting a division).
- addend  input  WIDTH  operand C (remainder when inverting a division).
- product  output  2*WIDTH  registered result A*B+C; held until the next result.
- busy  output  1  high whenever state != IDLE.
- done  output  1  registered one-cycle pulse when product becomes valid.

Behaviour:
- Interface: one clock (clk); reset rstn is asynchronous, active-low.
- Reset values: product=0, done=0, busy=0, state=IDLE, counter=0, all operand and working registers 0.
- Reset mid-operation aborts immediately to these values. No done pulse follows.
- Internal registers:
  - a_r: WIDTH bits, captured multiplicand.
  - c_r: WIDTH bits, captured addend.
  - hi: WIDTH+1 bits, partial-product upper half including carry.
  - lo: WIDTH bits, initialised to multiplier, shifted right.
  - cnt: $clog2(WIDTH+1) bits.
- States: IDLE, ADD, SHIFT, ACC, END.
- IDLE:
  - On start=1: capture a_r, c_r, lo=multiplier; set hi=0, cnt=0.
  - Next state is ACC if multiplicand==0 or multiplier==0, otherwise ADD.
  - With start=0, stay in IDLE.
- ADD: if lo[0]=1 then hi <= hi + {0,a_r}, otherwise hold. Next state SHIFT.
- SHIFT:
  - {hi,lo} <= {hi,lo} >> 1, with 0 shifted into the MSB of hi.
  - cnt <= cnt+1.
  - Next state: ACC if cnt==WIDTH-1 (pre-increment), else ADD.
- ACC:
  - Normal path: product <= {hi[WIDTH-1:0],lo} + {WIDTH zeros, c_r}.
  - Zero shortcut: product <= {WIDTH zeros, c_r}.
  - Next state END.
- END: next state IDLE. done <= 1 on the edge leaving END; otherwise done <= 0.
- Arithmetic: the maximum result (2^W-1)^2+(2^W-1) = 2^2W-2^W, so no overflow and no wrap is possible. Mod-2^2W arithmetic is never exercised.
- Latency, counted from the start-sample cycle as cycle 0:
  - Normal: ADD/SHIFT occupy cycles 1..2W, ACC 2W+1, END 2W+2; done=1 in cycle 2W+3 (W=4: cycle 11).
  - Zero shortcut: ACC cycle 1, END cycle 2, done in cycle 3.
- Handshake rules:
  - start is ignored while busy=1. Operands need only be valid in the start cycle.
  - The done cycle is IDLE, so start asserted in the same cycle as done is accepted: back-to-back throughput is 2W+3 cycles.
  - busy=1 from cycle 1 through END, and 0 in the done cycle.
  - product is updated only at ACC. It is stable from the done cycle until the next ACC, including through the next operation's ADD/SHIFT phase.
- Operand changes after capture have no effect on the running computation.
- The zero shortcut and the normal path must produce identical results for equal inputs; only latency differs.

Test Plan (WIDTH=4):
- Reset, then start with A=13, B=11, C=7 -> busy=1 in cycles 1..10; done pulse in cycle 11; product=0x96 (150), held after done falls.
- Start with A=15, B=15, C=15 -> done in cycle 11; product=0xF0 (240), the maximum with no overflow.
- Start with A=0, B=9, C=5 -> done in cycle 3; product=0x05. Repeat with A=9, B=0, C=0 -> product=0x00 at cycle 3.
- Start A=3, B=5, C=2 (product 17); re-assert start in the done cycle with A=6, B=7, C=1 -> second done exactly 11 cycles later with product=43; the first product (17) stays held until the second ACC.
- During an operation, pulse start with different operands and toggle the inputs in cycles 2..8 -> ignored; result equals that of the originally captured operands.
- Assert rstn=0 in cycle 5 of an operation -> product=0, busy=0, done=0 immediately, no done pulse afterwards; a fresh start then completes normally.
